pipeline_reg_vr: RTL and testbench



---
 rtl/pipeline_reg_vr_if.sv | 16 +
 rtl/pipeline_reg_vr.sv | 109 ++++++++++
 tb/tb_pipeline_reg_vr.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_reg_vr_if.sv
// Purpose : Valid/ready streaming handshake bundle for pipeline_reg_vr.
// Signals : valid - beat valid (producer -> consumer)
//           ready - consumer accepts the beat this cycle (consumer -> producer)
//           data  - WIDTH-bit beat payload (producer -> consumer)
// Modports: master - producer side (drives valid/data, receives ready)
//           slave  - consumer side (receives valid/data, drives ready)
interface pipeline_reg_vr_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_reg_vr.sv
// Purpose : DEPTH-deep, WIDTH-wide register pipeline with valid/ready
//           handshaking. Empty stages absorb beats even while the output is
//           stalled (bubble collapse), so full throughput is kept under
//           backpressure. Tracks stage occupancy in count.
// Ports   : clk   - clock, rising edge
//           rst   - synchronous active-high reset; clears all stages and
//                   forces s.ready/m.valid low while asserted
//           flush - synchronous clear of all valid bits (only when
//                   PIPELINE_REG_VR_FLUSH_EN is defined)
//           s     - upstream stream (slave modport)
//           m     - downstream stream (master modport)
//           count - number of occupied stages, 0..DEPTH
// Options : PIPELINE_REG_VR_FLUSH_EN - adds the flush port and its logic.
module pipeline_reg_vr #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef PIPELINE_REG_VR_FLUSH_EN
    input  logic                        flush,
`endif
    pipeline_reg_vr_if.slave            s,
    pipeline_reg_vr_if.master           m,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0]            in_vld;
    logic [DEPTH-1:0][WIDTH-1:0] in_data;
    logic [CW-1:0]               count_q;
    logic                        blocked;
    logic                        in_xfer;
    logic                        out_xfer;

    // rdy[i] = !valid[i] || rdy[i+1], unrolled from the output side with a
    // running OR so no vector bit depends on another bit of itself.
    always_comb begin
        logic acc;
        acc = m.ready;
        rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~vld_q[i];
            rdy[i] = acc;
        end
    end

    // What each stage would load: stage 0 from upstream, others from i-1.
    always_comb begin
        in_vld     = '0;
        in_data    = '0;
        in_vld[0]  = s.valid;
        in_data[0] = s.data;
        for (int i = 1; i < DEPTH; i++) begin
            in_vld[i]  = vld_q[i-1];
            in_data[i] = data_q[i-1];
        end
    end

`ifdef PIPELINE_REG_VR_FLUSH_EN
    assign blocked = rst | flush;
`else
    assign blocked = rst;
`endif

    // Handshake outputs are masked during reset/flush so no transfer can
    // be counted in a cycle whose state is being discarded anyway.
    assign s.ready  = rdy[0] & ~blocked;
    assign m.valid  = vld_q[DEPTH-1] & ~blocked;
    assign m.data   = data_q[DEPTH-1];
    assign in_xfer  = s.valid & s.ready;
    assign out_xfer = m.valid & m.ready;
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            data_q  <= {DEPTH{RESET_VAL}};
            count_q <= '0;
        end
`ifdef PIPELINE_REG_VR_FLUSH_EN
        else if (flush) begin
            // Only the valid bits clear; data registers keep their contents.
            vld_q   <= '0;
            count_q <= '0;
        end
`endif
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld_q[i] <= in_vld[i];
                    // Data only moves with a real beat so m.data keeps the
                    // last delivered value across bubbles.
                    if (in_vld[i])
                        data_q[i] <= in_data[i];
                end
            end
            case ({in_xfer, out_xfer})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_reg_vr.sv
// Self-checking bench for pipeline_reg_vr (DEPTH=3, WIDTH=8, non-zero
// RESET_VAL). A beat-level reference model tracks each beat's stage position
// in a queue: every cycle a beat advances one stage unless the beat ahead of
// it blocks the way, and the oldest beat leaves when presented with m_ready.
module tb_pipeline_reg_vr;
    localparam int             WIDTH = 8;
    localparam int             DEPTH = 3;
    localparam logic [7:0]     RV    = 8'hC3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [$clog2(DEPTH+1)-1:0] count;

    always #5 clk = ~clk;

    pipeline_reg_vr_if #(.WIDTH(WIDTH)) s_if ();
    pipeline_reg_vr_if #(.WIDTH(WIDTH)) m_if ();

    pipeline_reg_vr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) u_dut (
        .clk   (clk),
        .rst   (rst),
`ifdef PIPELINE_REG_VR_FLUSH_EN
        .flush (flush),
`endif
        .s     (s_if),
        .m     (m_if),
        .count (count)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        int               pos;
    } beat_t;

    beat_t            q[$];
    logic [WIDTH-1:0] last_out = RV;
    int n_tests = 0, n_fail = 0, n_in = 0, n_out = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model across the rising edge. Called at the falling edge.
    task automatic cyc(input bit sv, input logic [WIDTH-1:0] sd, input bit mr, input bit fl);
        bit blk, exp_sr, exp_mv;
        int lim, np;
        s_if.valid  = sv;
        s_if.data   = sd;
        m_if.ready  = mr;
        flush       = fl;
        #1;
        blk    = rst || fl;
        exp_sr = !blk && (q.size() < DEPTH || mr);
        exp_mv = !blk && q.size() > 0 && q[0].pos == DEPTH - 1;
        chk("s_ready", 32'(s_if.ready), 32'(exp_sr));
        chk("m_valid", 32'(m_if.valid), 32'(exp_mv));
        chk("m_data",  32'(m_if.data),  32'(last_out));
        chk("count",   32'(count),      32'(q.size()));
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_out = RV;
        end else if (fl) begin
            q.delete();
        end else begin
            if (exp_mv && mr) begin
                void'(q.pop_front());
                n_out++;
            end
            lim = DEPTH - 1;
            foreach (q[k]) begin
                np        = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim;
                q[k].pos  = np;
                lim       = np - 1;
            end
            if (sv && exp_sr) begin
                q.push_back('{d: sd, pos: 0});
                n_in++;
            end
            if (q.size() > 0 && q[0].pos == DEPTH - 1)
                last_out = q[0].d;
        end
        @(negedge clk);
    endtask

    initial begin
        int in0, out0, cycles;
        bit fl;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;

        // Reset: first edge establishes state, then two checked reset cycles.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc(1, 8'h5A, 1, 0);
        cyc(1, 8'h5A, 1, 0);
        rst = 1'b0;
        cyc(0, 8'h00, 1, 0);

        // Latency/throughput: 0x01..0x10 back to back with m_ready high.
        in0 = n_in; out0 = n_out;
        for (int i = 1; i <= 16; i++) cyc(1, 8'(i), 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 8'h00, 1, 0);
        chk("stream_in",  32'(n_in - in0),   32'd16);
        chk("stream_out", 32'(n_out - out0), 32'd16);

        // Backpressure and bubble collapse.
        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        cyc(0, 8'h00, 0, 0);
        cyc(1, 8'hA3, 0, 0);
        chk("bp_count", 32'(count), 32'(DEPTH));
        cyc(1, 8'hA4, 0, 0);
        out0 = n_out;
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0);
        chk("bp_drain", 32'(n_out - out0), 32'd3);

        // Simultaneous in/out while full.
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'hB0 + i), 0, 0);
        in0 = n_in; out0 = n_out;
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'hC0 + i), 1, 0);
        chk("full_in",    32'(n_in - in0),   32'd5);
        chk("full_out",   32'(n_out - out0), 32'd5);
        chk("full_count", 32'(count),        32'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 8'h00, 1, 0);

`ifdef PIPELINE_REG_VR_FLUSH_EN
        // Flush with two beats in flight and s_valid high.
        cyc(1, 8'hD1, 0, 0);
        cyc(1, 8'hD2, 0, 0);
        in0 = n_in; out0 = n_out;
        cyc(1, 8'hD3, 1, 1);
        chk("flush_xfer", 32'(n_in - in0 + n_out - out0), 32'd0);
        chk("flush_cnt",  32'(count), 32'd0);
        cyc(1, 8'hD4, 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 8'h00, 1, 0);
`endif

        // Random valid/ready until 10k beats delivered, bounded in cycles.
        out0   = n_out;
        cycles = 0;
        while (n_out - out0 < 10000 && cycles < 60000) begin
`ifdef PIPELINE_REG_VR_FLUSH_EN
            fl = ($urandom_range(0, 59) == 0);
`else
            fl = 1'b0;
`endif
            if ($urandom_range(0, 2999) == 0) begin
                rst = 1'b1;
                cyc(1, 8'($urandom), 1, 0);
                rst = 1'b0;
            end else begin
                cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0, fl);
            end
            chk("occupancy", 32'(count), 32'(q.size()));
            cycles++;
        end
        chk("rand_done", 32'(n_out - out0 >= 10000), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
